// File: rtl/tile_mem_responder.sv
// Responder for the tiled-MatMul address stream: A/B reads (tagged, in-order queue) and C result writes.
// Optional statistics counters are enabled by defining TILE_RESP_STATS_EN.
module tile_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] NULL_ADDR  = ADDR_WIDTH'(32'd99999999),
  parameter int                    MEM_LAT    = 2,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] agu_addr,
  input  logic [1:0]            agu_id,
  input  logic                  agu_valid,
  output logic                  read_req,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef TILE_RESP_STATS_EN
  ,
  output logic [31:0]           stat_rd,
  output logic [31:0]           stat_zf,
  output logic [31:0]           stat_wr,
  output logic [31:0]           stat_drop
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MEM_LAT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + MEM_LAT + 1);

  logic                  accept, ab_accept, c_accept, is_null, credit_ok;
  logic                  tag_exit, q_push, q_pop;
  logic [DATA_WIDTH-1:0] push_data;

  logic [MEM_LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0]    tag_id_q, tag_id_d;
  logic [MEM_LAT-1:0]    tag_zf_q, tag_zf_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_id_q, fifo_id_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]         q_count_q, q_count_d;
  logic [IW-1:0]         inflight_q, inflight_d;

  // Credits count both queued words and reads still in the tag pipe, so a
  // returning word always has a free queue slot.
  assign credit_ok = (CW'(q_count_q) + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign is_null   = (agu_addr == NULL_ADDR);

  always_comb begin
    read_req = 1'b0;
    if (!rst) begin
      case (agu_id)
        2'd0, 2'd1: read_req = credit_ok;
        2'd2:       read_req = res_valid;
        default:    read_req = 1'b1;
      endcase
    end
  end

  assign accept    = agu_valid && read_req && (agu_id != 2'd3);
  assign ab_accept = accept && !agu_id[1];
  assign c_accept  = accept && (agu_id == 2'd2);

  assign mem_re    = ab_accept && !is_null;
  assign mem_we    = c_accept && !is_null;
  assign mem_addr  = (mem_re || mem_we) ? agu_addr : '0;
  assign mem_wdata = mem_we ? res_data : '0;
  assign res_ready = c_accept;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_zf_d     = tag_zf_q;
    tag_vld_d[0] = ab_accept;
    tag_id_d[0]  = agu_id[0];
    tag_zf_d[0]  = is_null;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
      tag_zf_d[i]  = tag_zf_q[i-1];
    end
  end

  // Zero-fill slots ride the same pipe as real reads to keep ordering intact.
  assign tag_exit  = tag_vld_q[MEM_LAT-1];
  assign q_push    = tag_exit;
  assign push_data = tag_zf_q[MEM_LAT-1] ? '0 : mem_rdata;
  assign out_valid = (q_count_q != '0);
  assign q_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_id    = out_valid ? fifo_id_q[rd_ptr_q] : 1'b0;
  assign busy      = (inflight_q != '0) || (q_count_q != '0);

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    q_count_d   = q_count_q;
    inflight_d  = inflight_q;
    if (q_push) begin
      fifo_data_d[wr_ptr_q] = push_data;
      fifo_id_d[wr_ptr_q]   = tag_id_q[MEM_LAT-1];
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({q_push, q_pop})
      2'b10:   q_count_d = q_count_q + QW'(1);
      2'b01:   q_count_d = q_count_q - QW'(1);
      default: q_count_d = q_count_q;
    endcase
    case ({ab_accept, tag_exit})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      tag_zf_q   <= '0;
      fifo_id_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_count_q  <= '0;
      inflight_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      tag_zf_q    <= tag_zf_d;
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      q_count_q   <= q_count_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef TILE_RESP_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d, stat_zf_q, stat_zf_d;
  logic [31:0] stat_wr_q, stat_wr_d, stat_drop_q, stat_drop_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stat_rd_d   = sat_inc(stat_rd_q, mem_re);
    stat_zf_d   = sat_inc(stat_zf_q, ab_accept && is_null);
    stat_wr_d   = sat_inc(stat_wr_q, mem_we);
    stat_drop_d = sat_inc(stat_drop_q, c_accept && is_null);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q   <= '0;
      stat_zf_q   <= '0;
      stat_wr_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_rd_q   <= stat_rd_d;
      stat_zf_q   <= stat_zf_d;
      stat_wr_q   <= stat_wr_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_rd   = stat_rd_q;
  assign stat_zf   = stat_zf_q;
  assign stat_wr   = stat_wr_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule
